// File: rtl/hazard3_shift_stage.sv
// Shift/bit-manipulation stage with an external barrel shifter. Result is valid 2 cycles after request transfer.
// A held result blocks new requests until it is consumed. flush drops any work in flight.
module hazard3_shift_stage #(
  parameter int W_DATA        = 32,
  parameter int W_SHAMT       = 5,
  parameter bit EXTENSION_ZBB = 1'b1,
  parameter bit EXTENSION_ZBS = 1'b1
) (
  input  logic               clk,
  input  logic               rst_n,

  input  logic               req_valid,
  output logic               req_ready,
  input  logic [3:0]         req_op,
  input  logic [W_DATA-1:0]  req_rs1,
  input  logic [W_DATA-1:0]  req_rs2,

  input  logic               flush,

  output logic               resp_valid,
  input  logic               resp_ready,
  output logic [W_DATA-1:0]  resp_result,
  output logic               resp_err,

  output logic [W_DATA-1:0]  shift_din,
  output logic [W_SHAMT-1:0] shift_shamt,
  output logic               shift_right_nleft,
  output logic               shift_rotate,
  output logic               shift_arith,
  input  logic [W_DATA-1:0]  shift_dout
);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    EXEC = 2'd1,
    RESP = 2'd2
  } state_t;

  localparam logic [3:0] OP_SLL  = 4'd0;
  localparam logic [3:0] OP_SRL  = 4'd1;
  localparam logic [3:0] OP_SRA  = 4'd2;
  localparam logic [3:0] OP_ROL  = 4'd3;
  localparam logic [3:0] OP_ROR  = 4'd4;
  localparam logic [3:0] OP_BSET = 4'd5;
  localparam logic [3:0] OP_BCLR = 4'd6;
  localparam logic [3:0] OP_BINV = 4'd7;
  localparam logic [3:0] OP_BEXT = 4'd8;

  localparam logic [W_DATA-1:0] ONE_HOT0 = W_DATA'(1);

  state_t              state_q, state_d;
  logic [3:0]          op_q, op_d;
  logic [W_DATA-1:0]   rs1_q, rs1_d;
  logic [W_SHAMT-1:0]  shamt_q, shamt_d;
  logic [W_DATA-1:0]   result_q, result_d;
  logic                err_q, err_d;

  logic                req_fire;
  logic                op_ok;
  logic                unused_rs2_hi;

  // Shift amount is modulo W_DATA, so the upper operand bits never matter.
  assign unused_rs2_hi = ^req_rs2[W_DATA-1:W_SHAMT];

  function automatic logic op_legal(input logic [3:0] op);
    logic ok;
    ok = 1'b0;
    case (op)
      OP_SLL, OP_SRL, OP_SRA:             ok = 1'b1;
      OP_ROL, OP_ROR:                     ok = EXTENSION_ZBB;
      OP_BSET, OP_BCLR, OP_BINV, OP_BEXT: ok = EXTENSION_ZBS;
      default:                            ok = 1'b0;
    endcase
    return ok;
  endfunction

  assign op_ok = op_legal(op_q);

  assign resp_valid  = (state_q == RESP);
  assign resp_result = result_q;
  assign resp_err    = err_q;

  // Ready may follow resp_ready (pass-through in RESP); valid never looks at ready.
  assign req_ready = !flush && ((state_q == IDLE) || ((state_q == RESP) && resp_ready));
  assign req_fire  = req_valid && req_ready;

  // Shifter controls come only from captured state and are idle outside EXEC.
  always_comb begin
    shift_din         = '0;
    shift_shamt       = '0;
    shift_right_nleft = 1'b0;
    shift_rotate      = 1'b0;
    shift_arith       = 1'b0;
    if ((state_q == EXEC) && op_ok) begin
      shift_shamt = shamt_q;
      case (op_q)
        OP_SLL: begin
          shift_din = rs1_q;
        end
        OP_SRL, OP_BEXT: begin
          shift_din         = rs1_q;
          shift_right_nleft = 1'b1;
        end
        OP_SRA: begin
          shift_din         = rs1_q;
          shift_right_nleft = 1'b1;
          shift_arith       = 1'b1;
        end
        OP_ROL: begin
          shift_din    = rs1_q;
          shift_rotate = 1'b1;
        end
        OP_ROR: begin
          shift_din         = rs1_q;
          shift_right_nleft = 1'b1;
          shift_rotate      = 1'b1;
        end
        OP_BSET, OP_BCLR, OP_BINV: begin
          shift_din = ONE_HOT0;
        end
        default: begin
          shift_din = '0;
        end
      endcase
    end
  end

  always_comb begin
    state_d  = state_q;
    op_d     = op_q;
    rs1_d    = rs1_q;
    shamt_d  = shamt_q;
    result_d = result_q;
    err_d    = err_q;

    case (state_q)
      IDLE: begin
        if (req_fire) begin
          state_d = EXEC;
        end
      end
      EXEC: begin
        state_d = RESP;
        err_d   = !op_ok;
        if (!op_ok) begin
          result_d = '0;
        end else begin
          case (op_q)
            OP_BSET: result_d = rs1_q | shift_dout;
            OP_BCLR: result_d = rs1_q & ~shift_dout;
            OP_BINV: result_d = rs1_q ^ shift_dout;
            OP_BEXT: result_d = {{(W_DATA-1){1'b0}}, shift_dout[0]};
            default: result_d = shift_dout;
          endcase
        end
      end
      RESP: begin
        if (resp_ready) begin
          state_d = req_fire ? EXEC : IDLE;
        end
      end
      default: begin
        state_d = IDLE;
      end
    endcase

    if (req_fire) begin
      op_d    = req_op;
      rs1_d   = req_rs1;
      shamt_d = req_rs2[W_SHAMT-1:0];
    end

    if (flush) begin
      state_d  = IDLE;
      result_d = '0;
      err_d    = 1'b0;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q  <= IDLE;
      op_q     <= '0;
      rs1_q    <= '0;
      shamt_q  <= '0;
      result_q <= '0;
      err_q    <= 1'b0;
    end else begin
      state_q  <= state_d;
      op_q     <= op_d;
      rs1_q    <= rs1_d;
      shamt_q  <= shamt_d;
      result_q <= result_d;
      err_q    <= err_d;
    end
  end

endmodule

// File: doc/hazard3_shift_stage.md
HAZARD3_SHIFT_STAGE -- requirements
Module: hazard3_shift_stage

Interface
REQ-001 The module SHALL have parameter W_DATA, default 32, datapath width.
REQ-002 The module SHALL have parameter W_SHAMT, default 5, shift-amount width (log2 W_DATA).
REQ-003 The module SHALL have parameter EXTENSION_ZBB, default 1, enabling ROL/ROR.
REQ-004 The module SHALL have parameter EXTENSION_ZBS, default 1, enabling BSET/BCLR/BINV/BEXT.
REQ-005 The module SHALL have port clk  input  1  sole clock; all state on rising edge.
REQ-006 The module SHALL have port rst_n  input  1  asynchronous active-low reset.
REQ-007 The module SHALL have port req_valid  input  1  request present.
REQ-008 The module SHALL have port req_ready  output  1  request accepted this cycle if req_valid also high.
REQ-009 The module SHALL have port req_op  input  4  operation: 0 SLL, 1 SRL, 2 SRA, 3 ROL, 4 ROR, 5 BSET, 6 BCLR, 7 BINV, 8 BEXT, 9-15 illegal.
REQ-010 The module SHALL have ports req_rs1 and req_rs2  input  W_DATA  operands.
REQ-011 The module SHALL have port flush  input  1  discard any in-flight operation.
REQ-012 The module SHALL have port resp_valid  output  1  result present.
REQ-013 The module SHALL have port resp_ready  input  1  consumer takes result.
REQ-014 The module SHALL have port resp_result  output  W_DATA  result.
REQ-015 The module SHALL have port resp_err  output  1  operation illegal or disabled.
REQ-016 The module SHALL have ports shift_din (W_DATA), shift_shamt (W_SHAMT), shift_right_nleft, shift_rotate, shift_arith (1 each), all outputs, driving the external barrel shifter.
REQ-017 The module SHALL have port shift_dout  input  W_DATA  combinational barrel-shifter result.

Function
REQ-018 Handshake: transfer on req_valid && req_ready; transfer on resp_valid && resp_ready; valid SHALL NOT depend combinationally on ready of the same side.
REQ-019 FSM states SHALL be IDLE, EXEC, RESP; reset state IDLE.
REQ-020 req_ready SHALL be 1 in IDLE, 1 in RESP when resp_ready is 1, 0 in EXEC.
REQ-021 On request transfer: capture op, rs1, rs2[W_SHAMT-1:0] into registers; go to EXEC.
REQ-022 In EXEC shifter controls SHALL derive only from registered state: SLL (rs1, left, no rot, no arith); SRL (rs1, right); SRA (rs1, right, arith); ROL (rs1, left, rotate); ROR (rs1, right, rotate); BSET/BCLR/BINV (din = 1, left); BEXT (rs1, right); shamt = captured rs2 low bits.
REQ-023 Outside EXEC shifter controls SHALL be held at zero.
REQ-024 End of EXEC: register result; go to RESP; SLL..ROR result = shift_dout; BSET = rs1 | dout; BCLR = rs1 & ~dout; BINV = rs1 ^ dout; BEXT = zero-extended dout[0].
REQ-025 Illegal op, ROL/ROR with EXTENSION_ZBB=0, or B-ops with EXTENSION_ZBS=0: resp_result = 0, resp_err = 1; otherwise resp_err = 0.
REQ-026 Latency: resp_valid SHALL assert exactly 2 cycles after request transfer.
REQ-027 RESP with resp_ready=0: hold resp_valid, resp_result, resp_err stable; no new request accepted.
REQ-028 RESP with resp_ready=1 and req_valid=1: accept new request same cycle, go to EXEC (throughput one op per 2 cycles).
REQ-029 RESP with resp_ready=1 and req_valid=0: go to IDLE, resp_valid deasserts next cycle.
REQ-030 flush=1 SHALL force IDLE next cycle from any state, drop in-flight/held result, and suppress acceptance that cycle (req_ready = 0 while flush=1).
REQ-031 Shift amounts SHALL be taken modulo W_DATA (upper rs2 bits ignored).

Reset
REQ-032 While rst_n = 0: state IDLE, resp_valid = 0, resp_result = 0, resp_err = 0, captured operands 0, shifter controls 0; req_ready = 1 after release.
REQ-033 Reset asserted mid-operation SHALL discard the operation with no response ever issued.

Verification
REQ-034 SRA: rs1 = 0x80000010, rs2 = 4 -> after 2 cycles resp_result = 0xF8000001, resp_err = 0.
REQ-035 ROR: rs1 = 0x00000001, rs2 = 0x21 -> 0x80000000 (shamt 1); with EXTENSION_ZBB=0 -> 0x00000000, resp_err = 1.
REQ-036 BINV rs1 = 0xFFFF0000, rs2 = 31 -> 0x7FFF0000; BEXT rs1 = 0x00000400, rs2 = 10 -> 0x00000001.
REQ-037 Backpressure: resp_ready held 0 for 5 cycles -> result stable, req_ready = 0 throughout; then resp_ready = 1 with next req_valid -> accepted that cycle, next resp_valid 2 cycles later.
REQ-038 Flush in EXEC and in RESP -> no resp_valid issued, state IDLE next cycle; rst_n pulsed low in EXEC -> all outputs 0, no response.
REQ-039 op = 12 -> resp_result = 0, resp_err = 1 with normal 2-cycle latency.
